bist_misr_compactor: RTL and testbench
======================================

// Module: bist_misr_compactor
// PURPOSE
//  Downstream consumer of the BIST side of the BIST-mode demultiplexer.
//  - Drives the demux select (BIST_Mode_Sel) for the duration of a BIST run.
//  - Compacts the N-bit To_BIST response stream into an N-bit MISR signature over PATTERNS cycles.
//  - Reports completion, plus an optional pass/fail against a golden signature.
// PARAMETERS
//  N         4        response / signature width (matches demux N)
//  PATTERNS  16       number of capture cycles per run (>=1)
//  POLY      4'b0011  feedback taps XORed in when signature MSB is 1 (x^4+x+1 for N=4)
//  SEED      4'b0000  signature value at reset and at start of every run
//  GOLDEN    4'b0000  expected final signature (used only with BIST_MISR_GOLDEN_CMP_EN)
// PORTS
//  Clk            in   1  system clock, all state on rising edge
//  Rst            in   1  synchronous, active-high reset
//  BIST_Start     in   1  run request, sampled only in IDLE
//  From_DEMUX     in   N  response bits from demux To_BIST outputs
//  BIST_Mode_Sel  out  1  demux select; 1 = route logic outputs to BIST
//  BIST_Busy      out  1  run in progress (SETTLE or CAPTURE)
//  BIST_Done      out  1  run complete, signature valid
//  BIST_Pass      out  1  final signature == GOLDEN (valid while BIST_Done=1)
//  Signature      out  N  current MISR contents
// BEHAVIOUR
//  Reset (Rst=1 at clock edge): state=IDLE, Signature=SEED, counter=0; Mode_Sel, Busy, Done, Pass all 0.
//  Reset mid-run aborts the run immediately with the same values; no partial Done.
//  All outputs are registered. FSM states and transitions:
//   IDLE:    Start=1 -> SETTLE; Signature<=SEED; counter<=0; Done<=0.
//   SETTLE:  one cycle; Mode_Sel=1 so the demux path is stable. Next state is CAPTURE; no capture this cycle.
//   CAPTURE: each cycle Signature<=MISR(Signature,From_DEMUX); counter++.
//            On the capture with counter==PATTERNS-1 -> DONE.
//   DONE:    Done=1, Mode_Sel=0, Signature frozen. Start=1 -> SETTLE as from IDLE (Signature<=SEED, Done<=0).
//  MISR step: next = ((Signature<<1) truncated to N) ^ (Signature[N-1] ? POLY : 0) ^ From_DEMUX.
//  Mode_Sel and Busy are 1 exactly in SETTLE and CAPTURE.
//  Latency from Start sampled at edge t:
//   - SETTLE during cycle t+1.
//   - Captures at edges t+2 .. t+1+PATTERNS.
//   - Done=1 from edge t+1+PATTERNS.
//  Start while Busy is ignored (no restart, no queueing). Start held high in DONE starts a new run.
//  Counter width is $clog2(PATTERNS+1). The counter never wraps inside a run.
//  Start and Rst in the same cycle: Rst wins.
// CONFIGURATION
//  BIST_MISR_GOLDEN_CMP_EN defined:
//   - Pass is registered on entry to DONE as (final signature == GOLDEN).
//   - Pass is held through DONE and cleared on Start or Rst.
//  Not defined:
//   - BIST_Pass is tied to 0 and no comparator is built.
//   - The port list is identical in both builds.
// TESTING
//  1. Rst for 2 cycles -> Signature=4'h0; Mode_Sel, Busy, Done, Pass = 0; stays IDLE while Start=0.
//  2. PATTERNS=4, SEED=0, From_DEMUX=4'h1 constant, Start pulse
//     -> Signature 1,3,7,F after successive captures; Done=1 at t+5; Mode_Sel=1 during t+1..t+4.
//  3. SEED=4'h8, PATTERNS=1, From_DEMUX=0 -> final Signature=4'h3 (feedback path).
//  4. Start pulsed again during CAPTURE -> ignored; Done timing unchanged.
//     Start in DONE -> Signature reloads SEED, Done drops next cycle.
//  5. Rst asserted at second CAPTURE cycle -> next cycle IDLE, Signature=SEED, Done=0, Mode_Sel=0.
//  6. With BIST_MISR_GOLDEN_CMP_EN, GOLDEN=4'hF, scenario 2 -> Pass=1.
//     Flip one input bit -> Pass=0. Without the macro -> Pass always 0.

Source files
------------

// File: rtl/bist_misr_compactor.sv
// BIST response compactor: owns the demux select for a run and folds PATTERNS response words into an N-bit MISR.
// Latency: SETTLE one cycle after Start, then PATTERNS capture cycles; Done registered on the last capture edge.
// Backpressure: none; Start is ignored while busy, and a Start held in DONE begins a new run. Build with BIST_MISR_GOLDEN_CMP_EN for a golden check.
module bist_misr_compactor #(
    parameter int             N        = 4,
    parameter int             PATTERNS = 16,
    parameter logic [N-1:0]   POLY     = N'('b0011),
    parameter logic [N-1:0]   SEED     = '0,
    parameter logic [N-1:0]   GOLDEN   = '0
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         BIST_Start,
    input  logic [N-1:0] From_DEMUX,
    output logic         BIST_Mode_Sel,
    output logic         BIST_Busy,
    output logic         BIST_Done,
    output logic         BIST_Pass,
    output logic [N-1:0] Signature
);

    localparam int            CW   = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sig_q, sig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  misr_nxt;

    assign misr_nxt = (sig_q << 1) ^ (sig_q[N-1] ? POLY : '0) ^ From_DEMUX;

`ifdef BIST_MISR_GOLDEN_CMP_EN
    logic pass_q, pass_d;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
`ifdef BIST_MISR_GOLDEN_CMP_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (BIST_Start) begin
                    state_d = ST_SETTLE;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    done_d  = 1'b0;
`ifdef BIST_MISR_GOLDEN_CMP_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                sig_d = misr_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`ifdef BIST_MISR_GOLDEN_CMP_EN
                    pass_d  = (misr_nxt == GOLDEN);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Select and busy are registered copies of the next-state decode.
        sel_d  = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
        busy_d = sel_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BIST_MISR_GOLDEN_CMP_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end
    assign BIST_Pass = pass_q;
`else
    wire unused_golden = ^GOLDEN;
    assign BIST_Pass = 1'b0;
`endif

    assign BIST_Mode_Sel = sel_q;
    assign BIST_Busy     = busy_q;
    assign BIST_Done     = done_q;
    assign Signature     = sig_q;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Bench for bist_misr_compactor: a PATTERNS=4 instance with a golden of F, and a PATTERNS=1 SEED=8 instance for the feedback path.
module tb_bist_misr_compactor;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       start_a = 1'b0;
    logic [3:0] din_a = 4'h0;
    logic       sel_a, busy_a, done_a, pass_a;
    logic [3:0] sig_a;
    logic       start_b = 1'b0;
    logic [3:0] din_b = 4'h0;
    logic       sel_b, busy_b, done_b, pass_b;
    logic [3:0] sig_b;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];

    always #5 Clk = ~Clk;

    bist_misr_compactor #(.N(4), .PATTERNS(4), .POLY(4'b0011), .SEED(4'h0), .GOLDEN(4'hF)) dut_a (
        .Clk(Clk), .Rst(Rst), .BIST_Start(start_a), .From_DEMUX(din_a),
        .BIST_Mode_Sel(sel_a), .BIST_Busy(busy_a), .BIST_Done(done_a),
        .BIST_Pass(pass_a), .Signature(sig_a)
    );

    bist_misr_compactor #(.N(4), .PATTERNS(1), .POLY(4'b0011), .SEED(4'h8), .GOLDEN(4'h0)) dut_b (
        .Clk(Clk), .Rst(Rst), .BIST_Start(start_b), .From_DEMUX(din_b),
        .BIST_Mode_Sel(sel_b), .BIST_Busy(busy_b), .BIST_Done(done_b),
        .BIST_Pass(pass_b), .Signature(sig_b)
    );

    function automatic logic [3:0] misr_model(input logic [3:0] s, input logic [3:0] d);
        logic [3:0] sh;
        sh = {s[2:0], 1'b0};
        return sh ^ (s[3] ? 4'b0011 : 4'b0000) ^ d;
    endfunction

    function automatic logic golden_model(input logic [3:0] s);
`ifdef BIST_MISR_GOLDEN_CMP_EN
        return (s == 4'hF);
`else
        return 1'b0;
`endif
    endfunction

    // One full run on dut_a; optionally pulses Start during capture index 'mid'.
    task automatic run_a(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] d3, input int mid, input string nm,
                         output logic [3:0] final_sig);
        logic [3:0] seq[4];
        logic [3:0] m;
        logic [3:0] e;
        logic       ep;
        seq = '{d0, d1, d2, d3};
        m = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m = misr_model(m, seq[i]);
            exp_q.push_back(m);
        end
        ep = golden_model(m);
        start_a = 1'b1;
        @(posedge Clk); #1;
        start_a = 1'b0;
        tests_run++;
        if (sel_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0 || sig_a !== 4'h0 || pass_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_settle: sel=%b busy=%b done=%b pass=%b sig=%h, want 1 1 0 0 0", nm, sel_a, busy_a, done_a, pass_a, sig_a);
        end
        @(posedge Clk); #1;
        tests_run++;
        if (busy_a !== 1'b1 || sig_a !== 4'h0) begin
            tests_failed++;
            $display("FAIL %s_nocap_in_settle: busy=%b sig=%h, want 1 0", nm, busy_a, sig_a);
        end
        din_a = seq[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if (sig_a !== e) begin
                tests_failed++;
                $display("FAIL %s_capture%0d: sig=%h, want %h", nm, i, sig_a, e);
            end
            if (i < 3) begin
                tests_run++;
                if (done_a !== 1'b0 || sel_a !== 1'b1 || busy_a !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s_busy%0d: done=%b sel=%b busy=%b, want 0 1 1", nm, i, done_a, sel_a, busy_a);
                end
                din_a = seq[i+1];
            end
            start_a = (i < 3 && i == mid);
        end
        start_a = 1'b0;
        tests_run++;
        if (done_a !== 1'b1 || sel_a !== 1'b0 || busy_a !== 1'b0 || pass_a !== ep) begin
            tests_failed++;
            $display("FAIL %s_done: done=%b sel=%b busy=%b pass=%b, want 1 0 0 %b", nm, done_a, sel_a, busy_a, pass_a, ep);
        end
        din_a = ~din_a;
        @(posedge Clk); #1;
        tests_run++;
        if (sig_a !== m || done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== ep) begin
            tests_failed++;
            $display("FAIL %s_frozen: sig=%h done=%b busy=%b pass=%b, want %h 1 0 %b", nm, sig_a, done_a, busy_a, pass_a, m, ep);
        end
        final_sig = sig_a;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        tests_run++;
        if (sig_a !== 4'h0 || sel_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_a: sig=%h sel=%b busy=%b done=%b pass=%b, want 0 0 0 0 0", sig_a, sel_a, busy_a, done_a, pass_a);
        end
        tests_run++;
        if (sig_b !== 4'h8 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b: sig=%h busy=%b done=%b, want 8 0 0", sig_b, busy_b, done_b);
        end
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        tests_run++;
        if (sig_a !== 4'h0 || busy_a !== 1'b0 || sel_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: sig=%h busy=%b sel=%b done=%b, want 0 0 0 0", sig_a, busy_a, sel_a, done_a);
        end
    endtask

    task automatic test_capture_const();
        logic [3:0] f;
        run_a(4'h1, 4'h1, 4'h1, 4'h1, -1, "const1", f);
        tests_run++;
        if (f !== 4'hF) begin
            tests_failed++;
            $display("FAIL const1_final: sig=%h, want f", f);
        end
    endtask

    task automatic test_feedback();
        din_b = 4'h0;
        start_b = 1'b1;
        @(posedge Clk); #1;
        start_b = 1'b0;
        tests_run++;
        if (busy_b !== 1'b1 || sel_b !== 1'b1 || sig_b !== 4'h8) begin
            tests_failed++;
            $display("FAIL fb_settle: busy=%b sel=%b sig=%h, want 1 1 8", busy_b, sel_b, sig_b);
        end
        repeat (2) @(posedge Clk);
        #1;
        tests_run++;
        if (sig_b !== 4'h3 || done_b !== 1'b1 || busy_b !== 1'b0 || pass_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL fb_final: sig=%h done=%b busy=%b pass=%b, want 3 1 0 0", sig_b, done_b, busy_b, pass_b);
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] f;
        logic [3:0] r0, r1, r2, r3;
        r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
        // dut_a sits in DONE here, so this run also covers restart from DONE.
        run_a(r0, r1, r2, r3, 1, "midstart", f);
    endtask

    task automatic test_golden_flip();
        logic [3:0] f;
        run_a(4'h1, 4'h1, 4'h1, 4'h0, -1, "flip", f);
        tests_run++;
        if (pass_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL flip_pass: pass=%b, want 0", pass_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] f;
        for (int k = 0; k < 3; k++) begin
            run_a(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), -1, "b2b", f);
        end
        run_a(4'hF, 4'h0, 4'h8, 4'h3, 2, "pattern", f);
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1;
        din_a = 4'h5;
        @(posedge Clk); #1;
        start_a = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        tests_run++;
        if (busy_a !== 1'b1 || sig_a !== 4'h5) begin
            tests_failed++;
            $display("FAIL rstmid_pre: busy=%b sig=%h, want 1 5", busy_a, sig_a);
        end
        Rst = 1'b1;
        start_a = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        start_a = 1'b0;
        tests_run++;
        if (busy_a !== 1'b0 || sel_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 4'h0 || pass_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid: busy=%b sel=%b done=%b sig=%h pass=%b, want 0 0 0 0 0", busy_a, sel_a, done_a, sig_a, pass_a);
        end
        repeat (6) @(posedge Clk);
        #1;
        tests_run++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 4'h0) begin
            tests_failed++;
            $display("FAIL rstmid_idle: busy=%b done=%b sig=%h, want 0 0 0", busy_a, done_a, sig_a);
        end
    endtask

    initial begin
        test_reset();
        test_capture_const();
        test_feedback();
        test_start_ignored();
        test_golden_flip();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
